// File: rtl/lsu_bus_adapter_pkg.sv
// Shared encodings for the load/store unit: access size, load extension and the
// bus adapter state machine, plus the alignment rule used to reject accesses early.
package lsu_bus_adapter_pkg;

    localparam int DATA_SIZE_WIDTH   = 2;
    localparam int EXTEND_TYPE_WIDTH = 1;

    localparam logic [DATA_SIZE_WIDTH-1:0] DATA_SIZE_BYTE = 2'd0;
    localparam logic [DATA_SIZE_WIDTH-1:0] DATA_SIZE_HALF = 2'd1;
    localparam logic [DATA_SIZE_WIDTH-1:0] DATA_SIZE_WORD = 2'd2;

    localparam logic [EXTEND_TYPE_WIDTH-1:0] EXTEND_ZERO = 1'b0;
    localparam logic [EXTEND_TYPE_WIDTH-1:0] EXTEND_SIGN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // The unused size encoding is handled as a word everywhere, so it must be word aligned.
    function automatic logic is_misaligned(input logic [DATA_SIZE_WIDTH-1:0] size,
                                           input logic [1:0]                 addr_lo);
        logic mis;
        case (size)
            DATA_SIZE_BYTE: mis = 1'b0;
            DATA_SIZE_HALF: mis = addr_lo[0];
            DATA_SIZE_WORD: mis = (addr_lo != 2'b00);
            default:        mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: byte enables, store replication
// and load lane extraction with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_bus_adapter_pkg::*;
(
    input  logic [1:0]                   addr_lo,
    input  logic [DATA_SIZE_WIDTH-1:0]   data_size,
    input  logic [EXTEND_TYPE_WIDTH-1:0] extend_type,
    input  logic [31:0]                  wdata,
    input  logic [31:0]                  rdata,
    output logic [3:0]                   be,
    output logic [31:0]                  wdata_rep,
    output logic [31:0]                  rdata_ext
);

    logic [31:0] lane_s;

    // Move the addressed lane to bit 0, then size/extend it.
    always_comb begin
        lane_s    = rdata >> {addr_lo, 3'b000};
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
        case (data_size)
            DATA_SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                if (extend_type == EXTEND_SIGN) begin
                    rdata_ext = {{24{lane_s[7]}}, lane_s[7:0]};
                end else begin
                    rdata_ext = {24'h00_0000, lane_s[7:0]};
                end
            end
            DATA_SIZE_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                if (extend_type == EXTEND_SIGN) begin
                    rdata_ext = {{16{lane_s[15]}}, lane_s[15:0]};
                end else begin
                    rdata_ext = {16'h0000, lane_s[15:0]};
                end
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit: performs one memory-stage access on a request/grant/response bus,
// stalling the pipeline until it completes, errors on misalignment or timeout.
module lsu_bus_adapter
    import lsu_bus_adapter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_req_valid,
    input  logic                         mem_req_store,
    input  logic [15:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [DATA_SIZE_WIDTH-1:0]   mem_data_size,
    input  logic [EXTEND_TYPE_WIDTH-1:0] mem_extend_type,
    output logic                         mem_stall,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [15:0]                  bus_addr,
    output logic [3:0]                   bus_be,
    output logic [31:0]                  bus_wdata,
    input  logic                         bus_gnt,
    input  logic                         bus_rvalid,
    input  logic [31:0]                  bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t                   state_r;
    logic [CNT_W-1:0]             cnt_r;
    logic                         store_r;
    logic [1:0]                   addr_lo_r;
    logic [DATA_SIZE_WIDTH-1:0]   size_r;
    logic [EXTEND_TYPE_WIDTH-1:0] ext_r;

    logic                         rsp_valid_r;
    logic [31:0]                  rsp_rdata_r;
    logic                         rsp_err_r;
    logic                         bus_req_r;
    logic                         bus_we_r;
    logic [15:0]                  bus_addr_r;
    logic [3:0]                   bus_be_r;
    logic [31:0]                  bus_wdata_r;
    logic                         mem_stall_s;

    logic [1:0]                   align_addr_s;
    logic [DATA_SIZE_WIDTH-1:0]   align_size_s;
    logic [EXTEND_TYPE_WIDTH-1:0] align_ext_s;
    logic [3:0]                   be_s;
    logic [31:0]                  wdata_rep_s;
    logic [31:0]                  rdata_ext_s;

    // In IDLE the aligner steers the incoming request; afterwards the captured one.
    always_comb begin
        if (state_r == ST_IDLE) begin
            align_addr_s = mem_addr[1:0];
            align_size_s = mem_data_size;
            align_ext_s  = mem_extend_type;
        end else begin
            align_addr_s = addr_lo_r;
            align_size_s = size_r;
            align_ext_s  = ext_r;
        end
    end

    lsu_align u_align (
        .addr_lo     (align_addr_s),
        .data_size   (align_size_s),
        .extend_type (align_ext_s),
        .wdata       (mem_wdata),
        .rdata       (bus_rdata),
        .be          (be_s),
        .wdata_rep   (wdata_rep_s),
        .rdata_ext   (rdata_ext_s)
    );

    // Stall must follow mem_req_valid in the accept cycle, so it cannot be registered.
    always_comb begin
        if (!reset) begin
            mem_stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: mem_stall_s = mem_req_valid;
                ST_REQ:  mem_stall_s = 1'b1;
                ST_WAIT: mem_stall_s = 1'b1;
                ST_RESP: mem_stall_s = 1'b0;
                default: mem_stall_s = 1'b0;
            endcase
        end
    end

    // Access sequencer: accept, request, await data, respond; with timeout budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            store_r     <= 1'b0;
            addr_lo_r   <= 2'b00;
            size_r      <= DATA_SIZE_BYTE;
            ext_r       <= EXTEND_ZERO;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 16'h0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_req_valid) begin
                        store_r   <= mem_req_store;
                        addr_lo_r <= mem_addr[1:0];
                        size_r    <= mem_data_size;
                        ext_r     <= mem_extend_type;
                        cnt_r     <= '0;
                        if (is_misaligned(mem_data_size, mem_addr[1:0])) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ST_REQ;
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= mem_req_store;
                            bus_addr_r  <= {mem_addr[15:2], 2'b00};
                            bus_be_r    <= be_s;
                            bus_wdata_r <= mem_req_store ? wdata_rep_s : 32'h0000_0000;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req_r <= 1'b0;
                        if (store_r) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                        if (cnt_r != CNT_LAST) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        bus_req_r   <= 1'b0;
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= rdata_ext_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // The request still held this cycle is the one just answered.
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    bus_req_r   <= 1'b0;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= 16'h0000;
                    bus_be_r    <= 4'b0000;
                    bus_wdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    bus_req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_stall = mem_stall_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter (TIMEOUT = 4): stores, loads, misalignment,
// timeout, delayed grant and asynchronous reset mid-access.
module tb_lsu_bus_adapter;
    import lsu_bus_adapter_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_store;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_data_size;
    logic [0:0]  mem_extend_type;
    logic        mem_stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    lsu_bus_adapter #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_req_valid   (mem_req_valid),
        .mem_req_store   (mem_req_store),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_data_size   (mem_data_size),
        .mem_extend_type (mem_extend_type),
        .mem_stall       (mem_stall),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_gnt         (bus_gnt),
        .bus_rvalid      (bus_rvalid),
        .bus_rdata       (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"},   32'(bus_req),   32'd0);
        check_eq({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        check_eq({tag, "_rdata"}, rsp_rdata,      32'h0);
    endtask

    task automatic do_load(input string tag, input logic [15:0] addr, input logic [1:0] size,
                           input logic ext, input logic [31:0] rd, input logic [15:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        mem_req_valid = 1'b1; mem_req_store = 1'b0; mem_addr = addr;
        mem_data_size = size; mem_extend_type = ext; mem_wdata = 32'h0;
        #1;
        check_eq({tag, "_stall0"}, 32'(mem_stall), 32'd1);
        tick();
        check_eq({tag, "_req1"},  32'(bus_req), 32'd1);
        check_eq({tag, "_we1"},   32'(bus_we),  32'd0);
        check_eq({tag, "_addr1"}, 32'(bus_addr), 32'(exp_addr));
        check_eq({tag, "_be1"},   32'(bus_be),   32'(exp_be));
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check_eq({tag, "_req2"},   32'(bus_req),   32'd0);
        check_eq({tag, "_stall2"}, 32'(mem_stall), 32'd1);
        check_eq({tag, "_rspv2"},  32'(rsp_valid), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = rd;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        check_eq({tag, "_rspv3"},  32'(rsp_valid), 32'd1);
        check_eq({tag, "_data3"},  rsp_rdata,      exp_data);
        check_eq({tag, "_err3"},   32'(rsp_err),   32'd0);
        check_eq({tag, "_stall3"}, 32'(mem_stall), 32'd0);
        tick();
        check_quiet({tag, "_after"});
        mem_req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mem_req_valid = 1'b1; mem_req_store = 1'b0; mem_addr = 16'h0;
        mem_wdata = 32'h0; mem_data_size = DATA_SIZE_WORD; mem_extend_type = EXTEND_ZERO;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #12;
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_quiet("rst");
        check_eq("rst_be", 32'(bus_be), 32'd0);
        mem_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Store byte 0xA5 to 0x0013, immediate grant.
        mem_req_valid = 1'b1; mem_req_store = 1'b1; mem_addr = 16'h0013;
        mem_wdata = 32'h0000_00A5; mem_data_size = DATA_SIZE_BYTE;
        #1;
        check_eq("sb_stall0", 32'(mem_stall), 32'd1);
        check_eq("sb_req0",   32'(bus_req),   32'd0);
        tick();
        check_eq("sb_req1",   32'(bus_req),   32'd1);
        check_eq("sb_we1",    32'(bus_we),    32'd1);
        check_eq("sb_be1",    32'(bus_be),    32'h8);
        check_eq("sb_wdata1", bus_wdata,      32'hA5A5_A5A5);
        check_eq("sb_addr1",  32'(bus_addr),  32'h0010);
        check_eq("sb_stall1", 32'(mem_stall), 32'd1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check_eq("sb_rspv2",  32'(rsp_valid), 32'd1);
        check_eq("sb_err2",   32'(rsp_err),   32'd0);
        check_eq("sb_stall2", 32'(mem_stall), 32'd0);
        tick();
        check_quiet("sb_noreaccept");
        mem_req_valid = 1'b0;
        tick();

        do_load("lh_s", 16'h0022, DATA_SIZE_HALF, EXTEND_SIGN, 32'h8001_1234,
                16'h0020, 4'b1100, 32'hFFFF_8001);
        do_load("lh_z", 16'h0022, DATA_SIZE_HALF, EXTEND_ZERO, 32'h8001_1234,
                16'h0020, 4'b1100, 32'h0000_8001);
        do_load("lb_s", 16'h0011, DATA_SIZE_BYTE, EXTEND_SIGN, 32'h1234_80FF,
                16'h0010, 4'b0010, 32'hFFFF_FF80);
        do_load("lw",   16'h0044, DATA_SIZE_WORD, EXTEND_ZERO, 32'hDEAD_BEEF,
                16'h0044, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned word load.
        mem_req_valid = 1'b1; mem_req_store = 1'b0; mem_addr = 16'h0006;
        mem_data_size = DATA_SIZE_WORD; mem_extend_type = EXTEND_ZERO;
        #1;
        check_eq("mis_stall0", 32'(mem_stall), 32'd1);
        tick();
        check_eq("mis_req1",   32'(bus_req),   32'd0);
        check_eq("mis_rspv1",  32'(rsp_valid), 32'd1);
        check_eq("mis_err1",   32'(rsp_err),   32'd1);
        check_eq("mis_data1",  rsp_rdata,      32'h0);
        mem_req_valid = 1'b0;
        tick();
        check_quiet("mis_after");

        // Timeout: grant never comes.
        mem_req_valid = 1'b1; mem_req_store = 1'b0; mem_addr = 16'h0040;
        mem_data_size = DATA_SIZE_WORD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("to_req%0d", i), 32'(bus_req), 32'd1);
            check_eq($sformatf("to_rspv%0d", i), 32'(rsp_valid), 32'd0);
        end
        tick();
        check_eq("to_req_drop", 32'(bus_req),   32'd0);
        check_eq("to_rspv",     32'(rsp_valid), 32'd1);
        check_eq("to_err",      32'(rsp_err),   32'd1);
        check_eq("to_data",     rsp_rdata,      32'h0);
        mem_req_valid = 1'b0;
        tick();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        check_quiet("to_late1");
        tick();
        check_quiet("to_late2");

        // Store half with grant on the fourth REQ cycle.
        mem_req_valid = 1'b1; mem_req_store = 1'b1; mem_addr = 16'h0032;
        mem_wdata = 32'h0000_BEEF; mem_data_size = DATA_SIZE_HALF;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_wdata = 32'h0000_0000;
            check_eq($sformatf("dg_addr%0d", i),  32'(bus_addr),  32'h0030);
            check_eq($sformatf("dg_be%0d", i),    32'(bus_be),    32'hC);
            check_eq($sformatf("dg_wdata%0d", i), bus_wdata,      32'hBEEF_BEEF);
            check_eq($sformatf("dg_stall%0d", i), 32'(mem_stall), 32'd1);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check_eq("dg_rspv",  32'(rsp_valid), 32'd1);
        check_eq("dg_err",   32'(rsp_err),   32'd0);
        check_eq("dg_stall", 32'(mem_stall), 32'd0);
        mem_req_valid = 1'b0;
        tick();

        // Asynchronous reset while waiting for read data.
        mem_req_valid = 1'b1; mem_req_store = 1'b0; mem_addr = 16'h0050;
        mem_data_size = DATA_SIZE_WORD;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check_eq("ar_stall_wait", 32'(mem_stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_stall", 32'(mem_stall), 32'd0);
        check_eq("ar_addr",  32'(bus_addr),  32'd0);
        check_quiet("ar");
        mem_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        check_quiet("ar_stale");
        do_load("ar_lh", 16'h0060, DATA_SIZE_HALF, EXTEND_ZERO, 32'h5555_ABCD,
                16'h0060, 4'b0011, 32'h0000_ABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
